// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared counter encodings and predictor mode constants
package rv_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt_e;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter next-state logic
module sat_counter2
    import rv_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       inc_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_e'(cnt_i) != ST) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_e'(cnt_i) != SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with bimodal or gshare 2-bit PHT
module branch_predictor
    import rv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int MODE      = 0,
    parameter int HIST_BITS = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pred_tkn_o,
    output logic [XLEN-1:0] pred_pc_o,
    input  logic            upd_v_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_uncond_i,
    input  logic            upd_tkn_i,
    input  logic [XLEN-1:0] upd_tgt_i
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;
    localparam int GW   = (HIST_BITS < 1) ? 1 : HIST_BITS;

    logic            valid_q [ENTRIES];
    logic            valid_d [ENTRIES];
    logic [TAGW-1:0] tag_q   [ENTRIES];
    logic [TAGW-1:0] tag_d   [ENTRIES];
    logic [XLEN-1:0] tgt_q   [ENTRIES];
    logic [XLEN-1:0] tgt_d   [ENTRIES];
    logic            unc_q   [ENTRIES];
    logic            unc_d   [ENTRIES];
    logic [1:0]      pht_q   [ENTRIES];
    logic [1:0]      pht_d   [ENTRIES];
    logic [GW-1:0]   ghr_q, ghr_d;

    logic [IDX-1:0]  ghr_x;
    logic [IDX-1:0]  l_idx, u_idx, u_pidx;
    logic [TAGW-1:0] l_tag, u_tag;
    logic [1:0]      l_cnt, cnt_nxt;
    logic            l_hit;
    logic            unused_upd_lsb;

    assign unused_upd_lsb = ^upd_pc_i[1:0];

    // Bimodal mode indexes the PHT with the BTB index alone.
    assign ghr_x = (MODE == MODE_GSHARE) ? IDX'(ghr_q) : '0;

    assign l_idx = pc_i[IDX+1:2];
    assign l_tag = pc_i[XLEN-1:IDX+2];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_cnt = pht_q[l_idx ^ ghr_x];

    assign pred_tkn_o = l_hit && (unc_q[l_idx] || l_cnt[1]);
    assign pred_pc_o  = pred_tkn_o ? tgt_q[l_idx] : pc_i + XLEN'(4);

    assign u_idx  = upd_pc_i[IDX+1:2];
    assign u_tag  = upd_pc_i[XLEN-1:IDX+2];
    assign u_pidx = u_idx ^ ghr_x;

    sat_counter2 u_pht_cnt (
        .cnt_i (pht_q[u_pidx]),
        .inc_i (upd_tkn_i),
        .cnt_o (cnt_nxt)
    );

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        unc_d   = unc_q;
        pht_d   = pht_q;
        ghr_d   = ghr_q;
        if (upd_v_i && !stall_i) begin
            // A taken outcome both allocates on a miss and refreshes on a hit.
            if (upd_tkn_i) begin
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                tgt_d[u_idx]   = upd_tgt_i;
                unc_d[u_idx]   = upd_uncond_i;
            end
            if (!upd_uncond_i) begin
                pht_d[u_pidx] = cnt_nxt;
                if (MODE == MODE_GSHARE) ghr_d = GW'({ghr_q, upd_tkn_i});
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                pht_q[i]   <= WNT;
            end
            ghr_q <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            unc_q   <= unc_d;
            pht_q   <= pht_d;
            ghr_q   <= ghr_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for bimodal and gshare predictors
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        upd_v_i = 1'b0;
    logic [31:0] upd_pc_i = 32'h0;
    logic        upd_uncond_i = 1'b0;
    logic        upd_tkn_i = 1'b0;
    logic [31:0] upd_tgt_i = 32'h0;
    logic        tkn0, tkn1;
    logic [31:0] ppc0, ppc1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        tkn;
        logic [31:0] pc;
    } pred_t;

    pred_t exp_q[$];
    pred_t obs_q[$];

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .MODE(0), .HIST_BITS(4)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .pc_i(pc_i),
        .pred_tkn_o(tkn0), .pred_pc_o(ppc0),
        .upd_v_i(upd_v_i), .upd_pc_i(upd_pc_i), .upd_uncond_i(upd_uncond_i),
        .upd_tkn_i(upd_tkn_i), .upd_tgt_i(upd_tgt_i)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(16), .MODE(1), .HIST_BITS(4)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .pc_i(pc_i),
        .pred_tkn_o(tkn1), .pred_pc_o(ppc1),
        .upd_v_i(upd_v_i), .upd_pc_i(upd_pc_i), .upd_uncond_i(upd_uncond_i),
        .upd_tkn_i(upd_tkn_i), .upd_tgt_i(upd_tgt_i)
    );

    // Drive a lookup, push the expected prediction, then capture the observed one.
    task automatic look(input int sel, input string nm, input logic [31:0] pc,
                        input logic etkn, input logic [31:0] epc);
        pred_t e, o;
        pc_i = pc;
        e.name = nm; e.tkn = etkn; e.pc = epc;
        exp_q.push_back(e);
        #1;
        o.name = nm;
        o.tkn  = (sel != 0) ? tkn1 : tkn0;
        o.pc   = (sel != 0) ? ppc1 : ppc0;
        obs_q.push_back(o);
    endtask

    task automatic upd(input logic unc, input logic tkn, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic stl);
        upd_v_i = 1'b1; upd_uncond_i = unc; upd_tkn_i = tkn;
        upd_pc_i = pc; upd_tgt_i = tgt; stall_i = stl;
        @(posedge clk); #1;
        upd_v_i = 1'b0; stall_i = 1'b0;
    endtask

    task automatic test_reset();
        pred_t e, o;
        rst_i = 1'b1;
        @(posedge clk); #1;
        look(0, "rst_during_bi", 32'h100, 1'b0, 32'h104);
        look(1, "rst_during_gs", 32'h100, 1'b0, 32'h104);
        rst_i = 1'b0;
        @(posedge clk); #1;
        look(0, "rst_after", 32'h100, 1'b0, 32'h104);
        look(0, "rst_other_pc", 32'h7fc, 1'b0, 32'h800);
        look(0, "rst_wrap", 32'hffff_fffc, 1'b0, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.tkn !== e.tkn || o.pc !== e.pc) begin
                errors++;
                $display("FAIL %s: got tkn=%0b pc=%h expected tkn=%0b pc=%h", e.name, o.tkn, o.pc, e.tkn, e.pc);
            end
        end
    endtask

    task automatic test_bimodal();
        pred_t e, o;
        upd(1'b0, 1'b1, 32'h100, 32'h200, 1'b0);
        look(0, "bi_taken_wt", 32'h100, 1'b1, 32'h200);
        upd(1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
        look(0, "bi_wnt", 32'h100, 1'b0, 32'h104);
        upd(1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
        look(0, "bi_snt", 32'h100, 1'b0, 32'h104);
        upd(1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
        look(0, "bi_snt_sat", 32'h100, 1'b0, 32'h104);
        upd(1'b0, 1'b1, 32'h100, 32'h200, 1'b0);
        look(0, "bi_back_wnt", 32'h100, 1'b0, 32'h104);
        upd(1'b0, 1'b1, 32'h100, 32'h200, 1'b0);
        look(0, "bi_back_wt", 32'h100, 1'b1, 32'h200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.tkn !== e.tkn || o.pc !== e.pc) begin
                errors++;
                $display("FAIL %s: got tkn=%0b pc=%h expected tkn=%0b pc=%h", e.name, o.tkn, o.pc, e.tkn, e.pc);
            end
        end
    endtask

    task automatic test_stall_jal();
        pred_t e, o;
        stall_i = 1'b1;
        look(0, "stall_live", 32'h100, 1'b1, 32'h200);
        upd(1'b1, 1'b1, 32'h40, 32'h80, 1'b1);
        look(0, "stall_no_alloc", 32'h40, 1'b0, 32'h44);
        look(0, "stall_btb_kept", 32'h100, 1'b1, 32'h200);
        upd(1'b1, 1'b1, 32'h40, 32'h80, 1'b0);
        look(0, "jal_hit", 32'h40, 1'b1, 32'h80);
        look(0, "jal_evicts_alias", 32'h100, 1'b0, 32'h104);
        for (int i = 0; i < 3; i++) upd(1'b0, 1'b0, 32'h100, 32'h500, 1'b0);
        look(0, "jal_ignores_pht", 32'h40, 1'b1, 32'h80);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.tkn !== e.tkn || o.pc !== e.pc) begin
                errors++;
                $display("FAIL %s: got tkn=%0b pc=%h expected tkn=%0b pc=%h", e.name, o.tkn, o.pc, e.tkn, e.pc);
            end
        end
    endtask

    task automatic test_alias();
        pred_t e, o;
        upd(1'b0, 1'b1, 32'h100, 32'h200, 1'b0);
        look(0, "alias_first_wnt", 32'h100, 1'b0, 32'h104);
        upd(1'b0, 1'b1, 32'h140, 32'h240, 1'b0);
        look(0, "alias_old_miss", 32'h100, 1'b0, 32'h104);
        look(0, "alias_new_hit", 32'h140, 1'b1, 32'h240);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.tkn !== e.tkn || o.pc !== e.pc) begin
                errors++;
                $display("FAIL %s: got tkn=%0b pc=%h expected tkn=%0b pc=%h", e.name, o.tkn, o.pc, e.tkn, e.pc);
            end
        end
    endtask

    task automatic test_same_cycle();
        pred_t e, o;
        upd_v_i = 1'b1; upd_uncond_i = 1'b0; upd_tkn_i = 1'b1;
        upd_pc_i = 32'h100; upd_tgt_i = 32'h300;
        look(0, "same_cycle_old", 32'h100, 1'b0, 32'h104);
        @(posedge clk); #1;
        upd_v_i = 1'b0;
        look(0, "same_cycle_next", 32'h100, 1'b1, 32'h300);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.tkn !== e.tkn || o.pc !== e.pc) begin
                errors++;
                $display("FAIL %s: got tkn=%0b pc=%h expected tkn=%0b pc=%h", e.name, o.tkn, o.pc, e.tkn, e.pc);
            end
        end
    endtask

    task automatic test_gshare();
        pred_t e, o;
        logic  out;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) upd(1'b0, (i % 2) == 0, 32'h100, 32'h300, 1'b0);
        for (int k = 0; k < 8; k++) begin
            out = ((k % 2) == 0);
            look(1, $sformatf("gs_alt_%0d", k), 32'h100, out, out ? 32'h300 : 32'h104);
            upd(1'b0, out, 32'h100, 32'h300, 1'b0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.tkn !== e.tkn || o.pc !== e.pc) begin
                errors++;
                $display("FAIL %s: got tkn=%0b pc=%h expected tkn=%0b pc=%h", e.name, o.tkn, o.pc, e.tkn, e.pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        pred_t e, o;
        rst_i = 1'b1;
        upd_v_i = 1'b1; upd_uncond_i = 1'b1; upd_tkn_i = 1'b1;
        upd_pc_i = 32'h180; upd_tgt_i = 32'h380;
        @(posedge clk); #1;
        rst_i = 1'b0; upd_v_i = 1'b0;
        look(1, "mid_rst_btb", 32'h100, 1'b0, 32'h104);
        look(1, "mid_rst_drop_upd", 32'h180, 1'b0, 32'h184);
        look(0, "mid_rst_bi_btb", 32'h140, 1'b0, 32'h144);
        // With a cleared GHR, one T then four N brings the history back to zero.
        upd(1'b0, 1'b1, 32'h100, 32'h300, 1'b0);
        for (int i = 0; i < 4; i++) upd(1'b0, 1'b0, 32'h100, 32'h300, 1'b0);
        look(1, "mid_rst_ghr", 32'h100, 1'b1, 32'h300);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.tkn !== e.tkn || o.pc !== e.pc) begin
                errors++;
                $display("FAIL %s: got tkn=%0b pc=%h expected tkn=%0b pc=%h", e.name, o.tkn, o.pc, e.tkn, e.pc);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_bimodal();
        test_stall_jal();
        test_alias();
        test_same_cycle();
        test_gshare();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter ENTRIES, default 16, BTB and PHT depth; power of two, 2..64.
REQ-003 Parameter MODE, default 0, 0 = bimodal, 1 = gshare.
REQ-004 Parameter HIST_BITS, default 4, global history length; must be ≤ log2(ENTRIES); unused when MODE=0.
REQ-005 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_i  in  1  reset: synchronous, active-high.
REQ-007 stall_i  in  1  pipeline stall; blocks all state updates.
REQ-008 pc_i  in  XLEN  fetch PC being looked up (IF-stage next PC).
REQ-009 pred_tkn_o  out  1  predicted redirect for pc_i.
REQ-010 pred_pc_o  out  XLEN  predicted next PC for pc_i.
REQ-011 upd_v_i  in  1  resolved control-flow instruction present (MA stage, valid, not squashed).
REQ-012 upd_pc_i  in  XLEN  PC of the resolved instruction.
REQ-013 upd_uncond_i  in  1  1 = jal/jalr, 0 = conditional branch.
REQ-014 upd_tkn_i  in  1  actual outcome.
REQ-015 upd_tgt_i  in  XLEN  actual target when taken.

Function
REQ-016 IDX = log2(ENTRIES); index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
REQ-017 Each BTB entry holds valid, tag, target, uncond.
REQ-018 Each PHT entry holds one 2-bit saturating counter.
REQ-019 PHT index = BTB index when MODE=0; when MODE=1, PHT index = BTB index XOR zero-extended GHR.
REQ-020 Lookup is combinational, zero latency: hit = valid && tag match.
REQ-021 pred_tkn_o = hit && (uncond || counter[1]).
REQ-022 pred_pc_o = stored target when pred_tkn_o, else pc_i+4, modulo 2^XLEN.
REQ-023 Updates commit at the clock edge only when upd_v_i && !stall_i && !rst_i.
REQ-024 Conditional branch update: PHT counter increments on taken and saturates at 3; decrements on not-taken and saturates at 0.
REQ-025 Conditional branch update, MODE=1: GHR <= {GHR[HIST_BITS-2:0], upd_tkn_i}, shifted after the PHT index has been formed with the old GHR.
REQ-026 Unconditional update: PHT and GHR unchanged.
REQ-027 Update on BTB miss with upd_tkn_i=1 allocates the entry: valid=1, tag, target=upd_tgt_i, uncond=upd_uncond_i. Allocation overwrites any aliasing entry.
REQ-028 Update on BTB miss with upd_tkn_i=0: BTB unchanged.
REQ-029 Update on BTB hit with upd_tkn_i=1: target and uncond are rewritten.
REQ-030 Update on BTB hit with upd_tkn_i=0: BTB unchanged.
REQ-031 Same-cycle lookup and update to the same index: lookup returns pre-update contents; the new value is visible the next cycle.
REQ-032 stall_i=1: lookup outputs remain live; no state changes.

Reset
REQ-033 rst_i=1 at an edge: all BTB valid bits cleared, all PHT counters set to 2'b01 (weakly not-taken), GHR cleared. Pending update in that cycle is dropped.
REQ-034 During and after reset, until the first allocation: pred_tkn_o=0 and pred_pc_o=pc_i+4.
REQ-035 Reset mid-operation behaves identically to power-on reset.
REQ-036 Arrays are flop-based so that reset clears them in one cycle.

Structure
REQ-037 Shared package rv_pkg holds the counter encodings (SNT=0, WNT=1, WT=2, ST=3) and the MODE_BIMODAL / MODE_GSHARE constants.
REQ-038 Sub-module sat_counter2: 2-bit saturating up/down next-state logic; one instance on the PHT update path.

Verification
REQ-039 After reset, pc_i=0x100 -> pred_tkn_o=0, pred_pc_o=0x104.
REQ-040 MODE=0: one taken update at pc 0x100, target 0x200 -> next cycle pc_i=0x100 gives pred_tkn_o=1 (counter WT), pred_pc_o=0x200.
REQ-041 MODE=0, same branch: two not-taken updates -> counter reaches SNT, pred_tkn_o=0, pred_pc_o=0x104.
REQ-041 (cont.) A further not-taken update keeps the counter at 0.
REQ-042 jal at 0x40 (target 0x80) updated with stall_i=1 -> no hit. Repeated with stall_i=0 -> pred_tkn_o=1 at pc_i=0x40; three further non-taken updates to another branch leave it predicted taken.
REQ-043 ENTRIES=16: allocate 0x100, then allocate aliasing 0x140 -> lookup 0x100 misses, lookup 0x140 hits.
REQ-043 (cont.) Same-cycle lookup and update of 0x100 returns the old value.
REQ-044 MODE=1, HIST_BITS=4: alternating T/N branch at 0x100 trained 16 times -> prediction matches the next actual outcome for 8 consecutive checks.
REQ-044 (cont.) rst_i mid-sequence clears the BTB and GHR.
